// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings from the ALU decoder and the
// execution unit state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add multiplier datapath: one partial-product step per cycle,
// low WIDTH bits of the product only.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_next;

  // product exposes the accumulator including the current step so the FSM can
  // register the final value on the same edge that performs the last step
  assign acc_next = acc + (multiplier[0] ? multiplicand : '0);
  assign product  = acc_next;
  assign last     = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      count        <= '0;
    end else if (start) begin
      multiplicand <= a;
      multiplier   <= b;
      acc          <= '0;
      count        <= '0;
    end else if (step) begin
      acc          <= acc_next;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops and a WIDTH-cycle
// iterative multiply, with registered result, Zero flag and done pulse.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUcontrol,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  import alu_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] alu_value;
  logic             mul_start;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] mul_product;

  always_comb begin
    alu_value = '0;
    case (ALUcontrol)
      ALU_AND: alu_value = SrcA & SrcB;
      ALU_OR:  alu_value = SrcA | SrcB;
      ALU_ADD: alu_value = SrcA + SrcB;
      ALU_SUB: alu_value = SrcA - SrcB;
      ALU_SLT: alu_value = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: alu_value = '0;
    endcase
  end

  assign busy      = (state == MUL);
  assign mul_start = (state == IDLE) && start && (ALUcontrol == ALU_MUL);
  assign mul_step  = (state == MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step    (mul_step),
    .a       (SrcA),
    .b       (SrcB),
    .last    (mul_last),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (ALUcontrol == ALU_MUL) begin
              state <= MUL;
            end else begin
              ALUResult <= alu_value;
              Zero      <= (alu_value == '0);
              done      <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            ALUResult <= mul_product;
            Zero      <= (mul_product == '0);
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: behavioural model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ALUcontrol;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         busy;
  logic         done;
  logic [W-1:0] ALUResult;
  logic         Zero;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int done_seen;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ALUcontrol (ALUcontrol),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .busy       (busy),
    .done       (done),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  // Model: single-cycle ops complete next cycle; a multiply is just a countdown
  // of W busy cycles followed by the arithmetic product.
  logic [W-1:0] m_res     = '0;
  logic [W-1:0] m_pending = '0;
  bit           m_done    = 1'b0;
  bit           m_zero    = 1'b1;
  int           m_rem     = 0;

  function automatic logic [W-1:0] expected_op(input logic [2:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b110:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_res  <= '0;
      m_zero <= 1'b1;
      m_done <= 1'b0;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_res  <= m_pending;
          m_zero <= (m_pending == '0);
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (ALUcontrol == 3'b101) begin
          m_rem     <= W;
          m_pending <= SrcA * SrcB;
        end else begin
          m_res  <= expected_op(ALUcontrol, SrcA, SrcB);
          m_zero <= (expected_op(ALUcontrol, SrcA, SrcB) == '0);
          m_done <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_done", W'(done), W'(m_done));
      checkOutput("model_busy", W'(busy), W'(m_rem > 0));
      checkOutput("model_result", ALUResult, m_res);
      checkOutput("model_zero", W'(Zero), W'(m_zero));
    end
  end

  // Drives one start for a single cycle; returns in the cycle after acceptance.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    start      = 1'b1;
    ALUcontrol = op;
    SrcA       = a;
    SrcB       = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkSingle(input string name, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_res);
    applyStimulus(op, a, b);
    checkOutput({name, "_done"}, W'(done), W'(1));
    checkOutput({name, "_result"}, ALUResult, exp_res);
    checkOutput({name, "_zero"}, W'(Zero), W'(exp_res == '0));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    ALUcontrol = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_done", W'(done), W'(0));
    checkOutput("reset_busy", W'(busy), W'(0));
    checkOutput("reset_result", ALUResult, W'(0));
    checkOutput("reset_zero", W'(Zero), W'(1));
    cmp_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    $display("[TB] single-cycle operations");
    checkSingle("add_5_7", 3'b010, 32'd5, 32'd7, 32'd12);
    @(negedge clk);
    checkOutput("add_done_drop", W'(done), W'(0));
    checkOutput("add_hold", ALUResult, 32'd12);
    checkSingle("sub_9_9", 3'b100, 32'd9, 32'd9, 32'd0);
    checkSingle("slt_neg_pos", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1);
    checkSingle("slt_pos_neg", 3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0);
    checkSingle("slt_equal", 3'b110, 32'h8000_0000, 32'h8000_0000, 32'd0);
    checkSingle("and", 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    checkSingle("or", 3'b001, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834);
    checkSingle("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0);
    checkSingle("sub_wrap", 3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF);

    $display("[TB] multiply with ignored start and operand changes");
    applyStimulus(3'b101, 32'h0000_FFFF, 32'h0001_0001);
    checkOutput("mul1_busy_n1", W'(busy), W'(1));
    repeat (4) @(negedge clk);
    applyStimulus(3'b010, 32'd1, 32'd1);
    repeat (26) @(negedge clk);
    checkOutput("mul1_busy_n32", W'(busy), W'(1));
    checkOutput("mul1_nodone_n32", W'(done), W'(0));
    @(negedge clk);
    checkOutput("mul1_done", W'(done), W'(1));
    checkOutput("mul1_busy_n33", W'(busy), W'(0));
    checkOutput("mul1_result", ALUResult, 32'hFFFF_FFFF);

    $display("[TB] multiply wrap then back-to-back start");
    applyStimulus(3'b101, 32'h8000_0000, 32'd2);
    repeat (32) @(negedge clk);
    checkOutput("mul2_done", W'(done), W'(1));
    checkOutput("mul2_result", ALUResult, 32'd0);
    checkOutput("mul2_zero", W'(Zero), W'(1));
    checkSingle("b2b_or", 3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);

    $display("[TB] reset and start in the same cycle");
    rst = 1'b1;
    applyStimulus(3'b010, 32'd1, 32'd1);
    rst = 1'b0;
    checkOutput("rst_start_done", W'(done), W'(0));
    checkOutput("rst_start_result", ALUResult, W'(0));
    checkOutput("rst_start_zero", W'(Zero), W'(1));

    $display("[TB] reset during multiply");
    checkSingle("pre_mul_add", 3'b010, 32'd3, 32'd4, 32'd7);
    applyStimulus(3'b101, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", W'(busy), W'(0));
    checkOutput("abort_result", ALUResult, W'(0));
    checkOutput("abort_zero", W'(Zero), W'(1));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", W'(done_seen), W'(0));

    $display("[TB] unused encodings");
    checkSingle("code_011", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    checkSingle("add_nz", 3'b010, 32'd2, 32'd2, 32'd4);
    checkSingle("code_111", 3'b111, 32'h1234_5678, 32'h0000_0001, 32'd0);
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
